// File: rtl/multadd10.sv
// multadd10: 10-bit sequential multiply-add, product = multiplicand * multiplier + addend.
// Shift-and-add, LSB-first, one multiplier bit per clock through a single 20-bit adder.
// Optional build macro MULTADD10_EARLY_EXIT_EN: RUN also ends once the remaining
// multiplier bits are all zero. Results are identical to the fixed 10-cycle build.
module multadd10 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  multiplicand,
  input  logic [9:0]  multiplier,
  input  logic [9:0]  addend,
  output logic        ready,
  output logic        done,
  output logic [19:0] product,
  output logic [9:0]  result,
  output logic        overflow
);

  typedef enum logic {StIdle, StRun} state_t;

  state_t      r_state;
  logic [19:0] r_acc;
  logic [19:0] r_mcand;
  logic [9:0]  r_mplier;
  logic [3:0]  r_counter;
  logic        r_done;

  logic [19:0] w_sum;
  logic [9:0]  w_mplier_nxt;
  logic [3:0]  w_counter_nxt;
  logic        w_last;

  // Datapath for one iteration: partial-sum add, next multiplier bits, remaining count.
  always_comb begin
    w_sum         = r_acc + r_mcand;
    w_mplier_nxt  = r_mplier >> 1;
    w_counter_nxt = r_counter - 4'd1;
`ifdef MULTADD10_EARLY_EXIT_EN
    // No set bits left means every further iteration would add zero.
    w_last        = (w_counter_nxt == 4'd0) || (w_mplier_nxt == 10'd0);
`else
    w_last        = (w_counter_nxt == 4'd0);
`endif
  end

  // Control FSM and iteration registers; done is a registered RUN->IDLE pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_acc     <= 20'd0;
      r_mcand   <= 20'd0;
      r_mplier  <= 10'd0;
      r_counter <= 4'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_acc     <= {10'd0, addend};
            r_mcand   <= {10'd0, multiplicand};
            r_mplier  <= multiplier;
            r_counter <= 4'd10;
            r_state   <= StRun;
          end
        end
        StRun: begin
          if (r_mplier[0]) begin
            r_acc <= w_sum;
          end
          r_mcand   <= r_mcand << 1;
          r_mplier  <= w_mplier_nxt;
          r_counter <= w_counter_nxt;
          if (w_last) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Outputs decoded from registered state; product shows partial sums while running.
  always_comb begin
    ready    = (r_state == StIdle);
    done     = r_done;
    product  = r_acc;
    result   = r_acc[9:0];
    overflow = |r_acc[19:10];
  end

endmodule
